return_address_stack: RTL

Hardware return-address stack serving the jump controller's push_stack/pop_stack requests. A subroutine call (JSB) pushes the return PC. A return pops it, and the popped value must be usable as the next-PC source in the same cycle. The block sits beside the PC-source mux in the fetch stage and is written and read on a single clock.

---
 rtl/return_address_stack_if.sv | 26 ++
 rtl/return_address_stack.sv | 96 +++++++++
 2 files changed

// File: rtl/return_address_stack_if.sv
// Return-address stack request/status bundle between the jump controller and the stack.
interface return_address_stack_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 4
);
  logic              push_stack;
  logic              pop_stack;
  logic [ADDR_W-1:0] push_addr;
  logic              err_clr;
  logic [ADDR_W-1:0] top_addr;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push_stack, pop_stack, push_addr, err_clr,
    input  top_addr, empty, full, count, overflow_err, underflow_err
  );

  modport slave (
    input  push_stack, pop_stack, push_addr, err_clr,
    output top_addr, empty, full, count, overflow_err, underflow_err
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular-buffer return-address stack with a zero-latency top_addr for same-cycle RET.
// RAS_WRAP_EN: push while full overwrites the oldest entry instead of being dropped.
module return_address_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  return_address_stack_if.slave  ras
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  top_q, top_d, top_m1, wr_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_set, unf_set, wr_en;
  logic              empty, full;
`ifdef RAS_WRAP_EN
  logic [PTR_W-1:0]  base_q, base_d;
`endif

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign top_m1 = top_q - PTR_W'(1);

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    ovf_set = 1'b0;
    unf_set = ras.pop_stack & empty;
`ifdef RAS_WRAP_EN
    base_d  = base_q;
`endif
    if (ras.push_stack && ras.pop_stack && !empty) begin
      // call-and-return in one cycle replaces the top entry in place
      wr_en  = 1'b1;
      wr_idx = top_m1;
    end else if (ras.push_stack) begin
      if (!full) begin
        wr_en   = 1'b1;
        top_d   = top_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
`ifdef RAS_WRAP_EN
        // full means top and base coincide: the oldest slot takes the new address
        wr_en  = 1'b1;
        wr_idx = base_q;
        top_d  = top_q + PTR_W'(1);
        base_d = base_q + PTR_W'(1);
`else
        ovf_set = 1'b1;
`endif
      end
    end else if (ras.pop_stack && !empty) begin
      top_d   = top_m1;
      count_d = count_q - CNT_W'(1);
    end
    ovf_d = ovf_set | (ovf_q & ~ras.err_clr);
    unf_d = unf_set | (unf_q & ~ras.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef RAS_WRAP_EN
      base_q  <= '0;
`endif
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef RAS_WRAP_EN
      base_q  <= base_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= ras.push_addr;
  end

  assign ras.top_addr      = empty ? '0 : mem_q[top_m1];
  assign ras.empty         = empty;
  assign ras.full          = full;
  assign ras.count         = count_q;
  assign ras.overflow_err  = ovf_q;
  assign ras.underflow_err = unf_q;
endmodule
